// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // FSM states. The encodings are visible on the STATE debug port, so keep them fixed.
  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } sup_state_e;

  // Width of the shared phase timer. The timer must count up to the largest interval
  // measured in any state. RST_PULSE is included so that an unusually long PLL reset
  // pulse still fits.
  function automatic int timer_width(input int lock_timeout,
                                     input int stable_cycles,
                                     input int release_span,
                                     input int rst_pulse);
    int m;
    m = 2;
    if (lock_timeout  > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    if (release_span  > m) m = release_span;
    if (rst_pulse     > m) m = rst_pulse;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, with synchronous clear.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops. q is the second stage and is the only output that is safe to use.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make q see the previous value of meta, which is what gives two stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Controls PLL reset and staged release of the design resets, based on the synchronized PLL lock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int N_STAGES      = 3,
  parameter int STAGE_GAP     = 64,
  parameter int CNT_W         = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                PLL_LOCKED,
  output logic                PLL_RST,
  output logic [N_STAGES-1:0] RST_OUT,
  output logic                READY,
  output logic [CNT_W-1:0]    RETRY_CNT,
  output logic [CNT_W-1:0]    LOSS_CNT,
  output logic [2:0]          STATE
);

  localparam int TW = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP * N_STAGES, RST_PULSE);

  // The last timer value seen in each timed state before that state is left.
  localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(STAGE_GAP * (N_STAGES - 1));

  sup_state_e    state;
  logic [TW-1:0] timer;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .clr (RST),
    .d   (PLL_LOCKED),
    .q   (lock_s)
  );

  // Gives the reset pattern for a given number of cycles since RELEASE entry.
  // Stage k stays asserted until STAGE_GAP*k cycles have elapsed.
  function automatic logic [N_STAGES-1:0] stage_mask(input logic [TW-1:0] t);
    logic [N_STAGES-1:0] m;
    for (int k = 0; k < N_STAGES; k++) begin
      m[k] = (int'(t) < STAGE_GAP * k);
    end
    return m;
  endfunction

  // Increments and then holds at the maximum value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign STATE = state;

  // Supervisor FSM. Every output is assigned at the transition into the state that
  // produces it, so all outputs come directly from flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= PLL_RESET;
      timer     <= '0;
      PLL_RST   <= 1'b1;
      RST_OUT   <= '1;
      READY     <= 1'b0;
      RETRY_CNT <= '0;
      LOSS_CNT  <= '0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (timer == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            PLL_RST <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_LOCK: begin
          // A lock that arrives on the timeout cycle takes priority over the timeout.
          if (lock_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state     <= PLL_RESET;
            timer     <= '0;
            PLL_RST   <= 1'b1;
            RETRY_CNT <= sat_inc(RETRY_CNT);
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STABLE: begin
          // A drop in lock restarts the lock wait. It does not count as a retry.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state   <= RELEASE;
            timer   <= '0;
            RST_OUT <= stage_mask('0);
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            timer    <= '0;
            RST_OUT  <= '1;
            LOSS_CNT <= sat_inc(LOSS_CNT);
          end else if (timer == RELEASE_LAST) begin
            state   <= RUN;
            timer   <= '0;
            RST_OUT <= '0;
            READY   <= 1'b1;
          end else begin
            timer   <= timer + 1'b1;
            RST_OUT <= stage_mask(timer + 1'b1);
          end
        end

        RUN: begin
          // On lock loss, every stage asserts together. The PLL is reset again
          // only if the next lock wait times out.
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            timer    <= '0;
            RST_OUT  <= '1;
            READY    <= 1'b0;
            LOSS_CNT <= sat_inc(LOSS_CNT);
          end
        end

        default: begin
          state   <= PLL_RESET;
          timer   <= '0;
          PLL_RST <= 1'b1;
          RST_OUT <= '1;
          READY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random lock traffic, all compared against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int N_STAGES      = 3;
  localparam int STAGE_GAP     = 5;
  localparam int CNT_W         = 2;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;
  localparam int ALL_STAGES    = (1 << N_STAGES) - 1;

  localparam int P_RESET   = 0;
  localparam int P_WAIT    = 1;
  localparam int P_STABLE  = 2;
  localparam int P_RELEASE = 3;
  localparam int P_RUN     = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                locked;
  logic                pll_rst;
  logic [N_STAGES-1:0] rst_out;
  logic                ready;
  logic [CNT_W-1:0]    retry_cnt;
  logic [CNT_W-1:0]    loss_cnt;
  logic [2:0]          state;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_PULSE     (RST_PULSE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .N_STAGES      (N_STAGES),
    .STAGE_GAP     (STAGE_GAP),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .PLL_LOCKED (locked),
    .PLL_RST    (pll_rst),
    .RST_OUT    (rst_out),
    .READY      (ready),
    .RETRY_CNT  (retry_cnt),
    .LOSS_CNT   (loss_cnt),
    .STATE      (state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model. It tracks the phase, the cycles elapsed in that phase,
  // the two sync stages, and the event counts.
  int m_phase, m_el, m_retry, m_loss;
  bit m_s1, m_s2;

  function automatic int exp_rst_out();
    int v = 0;
    if (m_phase == P_RUN) return 0;
    if (m_phase != P_RELEASE) return ALL_STAGES;
    for (int k = 0; k < N_STAGES; k++)
      if (m_el < STAGE_GAP * k) v |= (1 << k);
    return v;
  endfunction

  task automatic model_step();
    bit ls;
    if (rst) begin
      m_phase = P_RESET; m_el = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      case (m_phase)
        P_RESET: begin
          m_el++;
          if (m_el == RST_PULSE) begin m_phase = P_WAIT; m_el = 0; end
        end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_STABLE; m_el = 0;
          end else begin
            m_el++;
            if (m_el == LOCK_TIMEOUT) begin
              m_phase = P_RESET; m_el = 0;
              if (m_retry < CNT_MAX) m_retry++;
            end
          end
        end
        P_STABLE: begin
          if (!ls) begin
            m_phase = P_WAIT; m_el = 0;
          end else begin
            m_el++;
            if (m_el == STABLE_CYCLES) begin m_phase = P_RELEASE; m_el = 0; end
          end
        end
        P_RELEASE, P_RUN: begin
          if (!ls) begin
            m_phase = P_WAIT; m_el = 0;
            if (m_loss < CNT_MAX) m_loss++;
          end else if (m_phase == P_RELEASE) begin
            m_el++;
            if (m_el > STAGE_GAP * (N_STAGES - 1)) begin m_phase = P_RUN; m_el = 0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Advances one clock, updates the model on the edge, and compares all outputs on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("state",     state,     m_phase);
    check("pll_rst",   pll_rst,   int'(m_phase == P_RESET));
    check("rst_out",   rst_out,   exp_rst_out());
    check("ready",     ready,     int'(m_phase == P_RUN));
    check("retry_cnt", retry_cnt, m_retry);
    check("loss_cnt",  loss_cnt,  m_loss);
  endtask

  task automatic run(input int n, input logic lvl);
    locked = lvl;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;

    // Reset state, including the first cycle after RST falls.
    do_reset();
    check("rst_state",   state,   P_RESET);
    check("rst_rst_out", rst_out, ALL_STAGES);

    // 1. Nominal lock.
    run(10, 1'b0);
    run(60, 1'b1);
    check("nom_ready", ready, 1);
    check("nom_retry", retry_cnt, 0);
    check("nom_loss",  loss_cnt, 0);

    // 3. A one-cycle glitch during STABLE.
    do_reset();
    run(10, 1'b0);
    run(5, 1'b1);
    run(1, 1'b0);
    run(50, 1'b1);
    check("glitch_ready", ready, 1);
    check("glitch_retry", retry_cnt, 0);

    // 4. Lock loss in RELEASE, after only stage 0 has been released.
    do_reset();
    run(8, 1'b0);
    locked = 1'b1;
    for (int i = 0; i < 100 && !(m_phase == P_RELEASE && m_el == 1); i++) cycle();
    check("rel_entered", state, P_RELEASE);
    run(3, 1'b0);
    check("rel_loss_rst_out", rst_out, ALL_STAGES);
    check("rel_loss_cnt",     loss_cnt, 1);
    run(60, 1'b1);
    check("rel_relock_ready", ready, 1);

    // 5. Lock loss in RUN, then no relock, so the timeout reset follows.
    run(3, 1'b0);
    check("run_loss_ready",   ready, 0);
    check("run_loss_pll_rst", pll_rst, 0);
    check("run_loss_cnt",     loss_cnt, 2);
    run(30, 1'b0);
    check("run_loss_retry",   retry_cnt, 1);

    // 2 and 6. Repeated timeouts saturate RETRY_CNT. Then reach RUN and apply a mid-run reset.
    do_reset();
    run(130, 1'b0);
    check("sat_retry",   retry_cnt, CNT_MAX);
    check("sat_rst_out", rst_out, ALL_STAGES);
    run(50, 1'b1);
    check("sat_run_ready", ready, 1);
    rst = 1'b1;
    cycle();
    check("mid_rst_state",   state, P_RESET);
    check("mid_rst_pll_rst", pll_rst, 1);
    check("mid_rst_rst_out", rst_out, ALL_STAGES);
    check("mid_rst_ready",   ready, 0);
    check("mid_rst_retry",   retry_cnt, 0);
    rst = 1'b0;

    // Random lock traffic, with occasional resets.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(15) == 0) do_reset();
      else run(int'($urandom_range(30, 1)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
